switch_box: RTL and testbench
=============================

Name: switch_box

Overview:
- Registered 4-direction routing switch box for the spatial fabric. Ports face north, west, south and east.
- Each of the four outputs drives a programmable choice: one of the four direction inputs, or constant zero.
- Routing comes from a small configuration register. After reset, traffic passes straight through: north↔south and west↔east.

Parameters:
- WIDTH, 32, data width of every direction port.
- REGISTERED, 1, 1 = outputs registered (1-cycle latency); 0 = outputs combinational from inputs and current config.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- inorth  input  WIDTH  data arriving from north neighbour.
- iwest  input  WIDTH  data arriving from west neighbour.
- isouth  input  WIDTH  data arriving from south neighbour.
- ieast  input  WIDTH  data arriving from east neighbour.
- cfg_we  input  1  config write strobe, sampled on rising clk.
- cfg_data  input  12  four 3-bit select fields: [2:0] onorth, [5:3] owest, [8:6] osouth, [11:9] oeast.
- onorth  output  WIDTH  data to north neighbour.
- owest  output  WIDTH  data to west neighbour.
- osouth  output  WIDTH  data to south neighbour.
- oeast  output  WIDTH  data to east neighbour.

Behaviour:
- Select codes:
  - 0 = north input.
  - 1 = west input.
  - 2 = south input.
  - 3 = east input.
  - 4–7 = constant zero.
- Loopback (an output selecting its own direction's input) is legal.
- Config register, 12 bits:
  - On reset low, it asynchronously loads the default: onorth=2 (south), owest=3 (east), osouth=0 (north), oeast=1 (west).
  - On a rising clk with cfg_we=1 and reset high, it loads cfg_data. All four fields update atomically.
  - There is no partial write.
- REGISTERED=1:
  - Each output register captures mux(select, inputs) on every rising clk while reset is high.
  - Latency is 1 cycle from input change to output.
  - While reset is low, all outputs are asynchronously 0.
- REGISTERED=0:
  - Outputs are purely combinational.
  - While reset is low, outputs still follow the default config, since the config is held at default during reset.
- Config write and data capture on the same edge: data captured on that edge uses the old config. The new routing is visible at the output on the next edge (2 edges after cfg_we is sampled, REGISTERED=1).
- Back-to-back cfg_we: the last write wins. Each intermediate config governs exactly the edge following its own write.
- Reset asserted mid-operation: outputs go to 0 and config returns to default immediately, without waiting for clk. On release, the first edge captures with the default routing.
- No arithmetic and no width conversion. Data passes bit-exact.
- No handshake. Every cycle is valid.

Decomposition:
- Shared package switch_box_pkg, containing:
  - Select-code constants SEL_NORTH=0, SEL_WEST=1, SEL_SOUTH=2, SEL_EAST=3, SEL_ZERO=4.
  - A 3-bit select typedef.
  - The 12-bit config typedef with named fields.
  - DEFAULT_CFG constant.
  - Default WIDTH.
- Sub-module switch_box_port_mux:
  - Inputs: four WIDTH inputs plus a 3-bit select.
  - Output: one WIDTH value.
  - Contains the optional output register, controlled by REGISTERED.
  - Instantiated four times, once per output direction.

Test Plan:
- Default routing:
  - Stimulus: reset low for 2 cycles, then high; inputs n=100, w=200, s=300, e=400.
  - Required: 0 on all outputs during reset. After the first edge past release: onorth=300, owest=400, osouth=100, oeast=200.
- Input change latency:
  - Stimulus: change inorth from 100 to 55 just after an edge.
  - Required: osouth stays 100 until the next edge, then shows 55 (REGISTERED=1). With REGISTERED=0, osouth shows 55 in the same cycle.
- Reprogram:
  - Stimulus: cfg_we=1 with all four fields=0 (broadcast north).
  - Required: all outputs equal 100 on the second edge after the write. The first edge still shows the default routing.
- Zero and loopback:
  - Stimulus: fields onorth=0 (loopback), owest=4, osouth=7, oeast=3.
  - Required: onorth=100, owest=0, osouth=0, oeast=400.
- Async reset mid-run:
  - Stimulus: after a custom config, pull reset low between edges.
  - Required: outputs are 0 immediately. After release, the default routing (300/400/100/200) returns without any cfg write.
- Back-to-back writes:
  - Stimulus: cfg_we on two consecutive edges, first with all fields=1, then all fields=3.
  - Required: outputs show 200 on one edge, then 400 on the following edge.

Source files
------------

// File: rtl/switch_box_pkg.sv
// Shared types and constants for the fabric switch box: select codes, config layout, reset routing.
package switch_box_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned SEL_W         = 3;
    localparam int unsigned CFG_W         = 4 * SEL_W;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t SEL_NORTH = 3'd0;
    localparam sel_t SEL_WEST  = 3'd1;
    localparam sel_t SEL_SOUTH = 3'd2;
    localparam sel_t SEL_EAST  = 3'd3;
    localparam sel_t SEL_ZERO  = 3'd4;

    // Field order puts onorth in the LSBs to match the cfg_data bit layout.
    typedef struct packed {
        sel_t oeast;
        sel_t osouth;
        sel_t owest;
        sel_t onorth;
    } cfg_t;

    localparam cfg_t DEFAULT_CFG = cfg_t'({SEL_WEST, SEL_NORTH, SEL_EAST, SEL_SOUTH});

endpackage

// File: rtl/switch_box_port_mux.sv
// One output direction: 5-way select (four inputs or zero) with an optional output register.
module switch_box_port_mux
    import switch_box_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter bit          REGISTERED = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_north,
    input  logic [WIDTH-1:0] in_west,
    input  logic [WIDTH-1:0] in_south,
    input  logic [WIDTH-1:0] in_east,
    input  sel_t             sel,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mux_c;

    // Codes 4..7 all decode to constant zero.
    always_comb begin
        mux_c = '0;
        case (sel)
            SEL_NORTH: mux_c = in_north;
            SEL_WEST:  mux_c = in_west;
            SEL_SOUTH: mux_c = in_south;
            SEL_EAST:  mux_c = in_east;
            default:   mux_c = '0;
        endcase
    end

    generate
        if (REGISTERED) begin : g_reg
            logic [WIDTH-1:0] dout_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q <= '0;
                end else begin
                    dout_q <= mux_c;
                end
            end

            assign dout = dout_q;
        end else begin : g_comb
            assign dout = mux_c;
        end
    endgenerate

endmodule

// File: rtl/switch_box.sv
// Four-direction routing switch box with a 12-bit routing config register, default straight-through.
module switch_box
    import switch_box_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter bit          REGISTERED = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] inorth,
    input  logic [WIDTH-1:0] iwest,
    input  logic [WIDTH-1:0] isouth,
    input  logic [WIDTH-1:0] ieast,
    input  logic             cfg_we,
    input  logic [CFG_W-1:0] cfg_data,
    output logic [WIDTH-1:0] onorth,
    output logic [WIDTH-1:0] owest,
    output logic [WIDTH-1:0] osouth,
    output logic [WIDTH-1:0] oeast
);

    cfg_t cfg_q;

    // Whole-word load keeps all four selects consistent; same-edge data capture sees the old value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_q <= DEFAULT_CFG;
        end else if (cfg_we) begin
            cfg_q <= cfg_t'(cfg_data);
        end
    end

    switch_box_port_mux #(.WIDTH(WIDTH), .REGISTERED(REGISTERED)) u_mux_north (
        .clk(clk), .rst_n(reset),
        .in_north(inorth), .in_west(iwest), .in_south(isouth), .in_east(ieast),
        .sel(cfg_q.onorth), .dout(onorth)
    );

    switch_box_port_mux #(.WIDTH(WIDTH), .REGISTERED(REGISTERED)) u_mux_west (
        .clk(clk), .rst_n(reset),
        .in_north(inorth), .in_west(iwest), .in_south(isouth), .in_east(ieast),
        .sel(cfg_q.owest), .dout(owest)
    );

    switch_box_port_mux #(.WIDTH(WIDTH), .REGISTERED(REGISTERED)) u_mux_south (
        .clk(clk), .rst_n(reset),
        .in_north(inorth), .in_west(iwest), .in_south(isouth), .in_east(ieast),
        .sel(cfg_q.osouth), .dout(osouth)
    );

    switch_box_port_mux #(.WIDTH(WIDTH), .REGISTERED(REGISTERED)) u_mux_east (
        .clk(clk), .rst_n(reset),
        .in_north(inorth), .in_west(iwest), .in_south(isouth), .in_east(ieast),
        .sel(cfg_q.oeast), .dout(oeast)
    );

endmodule

// File: tb/tb_switch_box.sv
// Directed bench for switch_box (REGISTERED=1): expected routing queued at drive time, checked after each edge.
module tb_switch_box;

    typedef struct packed {
        logic [31:0] n;
        logic [31:0] w;
        logic [31:0] s;
        logic [31:0] e;
    } quad_t;

    logic        clk;
    logic        reset;
    logic        cfg_we;
    logic [11:0] cfg_data;
    quad_t       din;
    logic [31:0] onorth, owest, osouth, oeast;

    quad_t       exp_q[$];
    logic [11:0] m_cfg;
    int          n_assert;
    int          n_fail;

    localparam logic [11:0] DEF_CFG = 12'b001_000_011_010;

    switch_box #(.WIDTH(32), .REGISTERED(1'b1)) dut (
        .clk(clk), .reset(reset),
        .inorth(din.n), .iwest(din.w), .isouth(din.s), .ieast(din.e),
        .cfg_we(cfg_we), .cfg_data(cfg_data),
        .onorth(onorth), .owest(owest), .osouth(osouth), .oeast(oeast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pick(input logic [2:0] s, input quad_t d);
        case (s)
            3'd0:    return d.n;
            3'd1:    return d.w;
            3'd2:    return d.s;
            3'd3:    return d.e;
            default: return 32'd0;
        endcase
    endfunction

    function automatic quad_t route(input logic [11:0] c, input quad_t d);
        quad_t r;
        r.n = pick(c[2:0], d);
        r.w = pick(c[5:3], d);
        r.s = pick(c[8:6], d);
        r.e = pick(c[11:9], d);
        return r;
    endfunction

    task automatic check(input string tag, input quad_t obs, input quad_t exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed n=%0d w=%0d s=%0d e=%0d expected n=%0d w=%0d s=%0d e=%0d",
                   tag, obs.n, obs.w, obs.s, obs.e, exp_v.n, exp_v.w, exp_v.s, exp_v.e);
        end
    endtask

    function automatic quad_t outs();
        quad_t q;
        q.n = onorth; q.w = owest; q.s = osouth; q.e = oeast;
        return q;
    endfunction

    // Drive one cycle of stimulus, queue the model's prediction, then compare after the edge.
    task automatic cycle(input string tag, input logic we, input logic [11:0] data);
        quad_t e;
        cfg_we   = we;
        cfg_data = data;
        exp_q.push_back(route(m_cfg, din));
        @(posedge clk);
        if (we) m_cfg = data;
        #1;
        cfg_we = 1'b0;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, outs(), e);
        end
    endtask

    task automatic expect_const(input string tag, input logic [31:0] n, input logic [31:0] w,
                                input logic [31:0] s, input logic [31:0] e);
        quad_t q;
        q.n = n; q.w = w; q.s = s; q.e = e;
        check(tag, outs(), q);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b0;
        cfg_we   = 1'b0;
        cfg_data = 12'h000;
        din      = '{n: 32'd100, w: 32'd200, s: 32'd300, e: 32'd400};
        m_cfg    = DEF_CFG;

        // Reset held for two cycles: outputs must stay zero.
        #1 expect_const("reset_t0", 0, 0, 0, 0);
        @(posedge clk); #1 expect_const("reset_e1", 0, 0, 0, 0);
        @(posedge clk); #1 expect_const("reset_e2", 0, 0, 0, 0);
        reset = 1'b1;
        #1 expect_const("reset_released_pre_edge", 0, 0, 0, 0);

        cycle("default_route", 1'b0, 12'h000);
        expect_const("default_values", 300, 400, 100, 200);

        // Input change latency.
        din.n = 32'd55;
        #1 expect_const("latency_hold", 300, 400, 100, 200);
        cycle("latency_update", 1'b0, 12'h000);
        expect_const("latency_value", 300, 400, 55, 200);
        din.n = 32'd100;
        cycle("restore_north", 1'b0, 12'h000);

        // Reprogram to broadcast north; first edge still uses default.
        cycle("reprog_first_edge", 1'b1, 12'h000);
        expect_const("reprog_first_vals", 300, 400, 100, 200);
        cycle("reprog_second_edge", 1'b0, 12'h000);
        expect_const("reprog_broadcast", 100, 100, 100, 100);

        // Zero codes and loopback.
        cycle("zero_loop_write", 1'b1, 12'b011_111_100_000);
        cycle("zero_loop_route", 1'b0, 12'h000);
        expect_const("zero_loop_vals", 100, 0, 0, 400);

        // Async reset between edges.
        #3 reset = 1'b0;
        #1 expect_const("async_reset_immediate", 0, 0, 0, 0);
        m_cfg = DEF_CFG;
        @(posedge clk); #1 expect_const("async_reset_held", 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        cycle("post_reset_default", 1'b0, 12'h000);
        expect_const("post_reset_vals", 300, 400, 100, 200);

        // Back-to-back writes.
        cycle("b2b_write1", 1'b1, 12'b001_001_001_001);
        cycle("b2b_write2", 1'b1, 12'b011_011_011_011);
        expect_const("b2b_west", 200, 200, 200, 200);
        cycle("b2b_final", 1'b0, 12'h000);
        expect_const("b2b_east", 400, 400, 400, 400);

        // Random traffic with occasional reconfiguration.
        for (int i = 0; i < 40; i++) begin
            din.n = $urandom;
            din.w = $urandom;
            din.s = $urandom;
            din.e = $urandom;
            cycle("random", ($urandom_range(0, 3) == 0), 12'($urandom));
        end

        n_assert++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d entries expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
